// File: rtl/uart_byte_fifo_if.sv
// uart_byte_fifo_if: the write side, read side and status signals of the byte FIFO.
//   master : producer/consumer side (drives wr_en, wr_data, rd_take, ovf_clr)
//   slave  : the FIFO itself (drives full, overflow, rd_valid, rd_data, count, high_water)
// DEPTH and WIDTH must match the parameters of the uart_byte_fifo instance that uses it.
interface uart_byte_fifo_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic             overflow;
    logic             ovf_clr;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_take;
    logic [AW:0]      count;
    logic [AW:0]      high_water;

    modport master (
        output wr_en, wr_data, ovf_clr, rd_take,
        input  full, overflow, rd_valid, rd_data, count, high_water
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr, rd_take,
        output full, overflow, rd_valid, rd_data, count, high_water
    );
endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: first-word fall-through byte FIFO between the UART receiver and transmitter.
// Buffers bursts of received bytes, flags dropped writes (sticky overflow) and tracks the
// occupancy high-water mark for debug visibility.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : uart_byte_fifo_if.slave
//          wr_en/wr_data      write strobe and byte
//          rd_valid/rd_data   head entry (combinational read of the head slot)
//          rd_take            consumer has taken the head
//          full/count         occupancy status
//          overflow           sticky dropped-write flag
//          high_water         max occupancy since reset or ovf_clr
//          ovf_clr            clears overflow and reloads high_water with the new count
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    uart_byte_fifo_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   high_water_q, high_water_d;
    logic          overflow_q, overflow_d;

    logic full, rd_valid;
    logic do_rd, do_wr, drop;

    // Status comes only from registered count: no input-to-output combinational path.
    assign rd_valid = (count_q != '0);
    assign full     = (count_q == FullCount);

    // A write while full is still accepted if the head leaves in the same cycle.
    assign do_rd = bus.rd_take & rd_valid;
    assign do_wr = bus.wr_en & (~full | do_rd);
    assign drop  = bus.wr_en & ~do_wr;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        high_water_d = high_water_q;

        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (do_wr && !do_rd) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - (AW + 1)'(1);
        end

        // A drop in the same cycle as a clear wins: the loss must stay visible.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end

        if (bus.ovf_clr || (count_d > high_water_q)) begin
            high_water_d = count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            high_water_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            high_water_q <= high_water_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && do_wr) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.rd_data    = mem[rd_ptr_q];
    assign bus.rd_valid   = rd_valid;
    assign bus.full       = full;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.high_water = high_water_q;

endmodule

// File: tb/tb_uart_byte_fifo.sv
module tb_uart_byte_fifo;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_byte_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    uart_byte_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue plus the two status flags.
    logic [WIDTH-1:0] mq [$];
    bit               movf;
    int               mhw;

    int n_cmp = 0;
    int n_err = 0;

    // One clock of stimulus; the model advances at the same edge. Outputs are
    // stable for checking when this returns (1 time unit after the edge).
    task automatic drive(input bit wr, input logic [WIDTH-1:0] d, input bit take,
                         input bit clr, input bit r);
        bit took, wrote;
        bus.wr_en   = wr;
        bus.wr_data = d;
        bus.rd_take = take;
        bus.ovf_clr = clr;
        rst         = r;
        @(posedge clk);
        if (r) begin
            mq.delete();
            movf = 0;
            mhw  = 0;
        end else begin
            took  = take && (mq.size() > 0);
            wrote = wr && ((mq.size() < DEPTH) || took);
            if (took) void'(mq.pop_front());
            if (wrote) mq.push_back(d);
            if (wr && !wrote) movf = 1;
            else if (clr) movf = 0;
            if (clr || mq.size() > mhw) mhw = mq.size();
        end
        #1;
        bus.wr_en   = 1'b0;
        bus.rd_take = 1'b0;
        bus.ovf_clr = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic test_reset();
        drive(0, 8'h00, 0, 0, 1);
        n_cmp++; if (bus.count !== '0) begin n_err++;
            $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.full !== 1'b0) begin n_err++;
            $display("FAIL reset_full: got %b want 0", bus.full); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++;
            $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        n_cmp++; if (bus.high_water !== '0) begin n_err++;
            $display("FAIL reset_high_water: got %0d want 0", bus.high_water); end
        drive(0, 8'h00, 1, 0, 0);
        n_cmp++; if (bus.count !== '0 || bus.rd_valid !== 1'b0 || bus.high_water !== '0)
        begin n_err++;
            $display("FAIL empty_take: count %0d valid %b hw %0d want 0/0/0",
                     bus.count, bus.rd_valid, bus.high_water); end
    endtask

    task automatic test_single();
        drive(1, 8'h41, 0, 0, 0);
        n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h41 || bus.count !== 1)
        begin n_err++;
            $display("FAIL single_write: valid %b data %h count %0d want 1/41/1",
                     bus.rd_valid, bus.rd_data, bus.count); end
        drive(0, 8'h00, 0, 0, 0);
        drive(0, 8'h00, 0, 0, 0);
        drive(0, 8'h00, 1, 0, 0);
        n_cmp++; if (bus.rd_valid !== 1'b0 || bus.count !== '0) begin n_err++;
            $display("FAIL single_take: valid %b count %0d want 0/0",
                     bus.rd_valid, bus.count); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) drive(1, 8'(i), 0, 0, 0);
        n_cmp++; if (bus.full !== 1'b1 || bus.count !== 16 || bus.high_water !== 16)
        begin n_err++;
            $display("FAIL fill: full %b count %0d hw %0d want 1/16/16",
                     bus.full, bus.count, bus.high_water); end
        drive(1, 8'hAA, 0, 0, 0);
        n_cmp++; if (bus.overflow !== 1'b1 || bus.count !== 16) begin n_err++;
            $display("FAIL drop: overflow %b count %0d want 1/16", bus.overflow, bus.count); end
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(i)) begin n_err++;
                $display("FAIL drain_%0d: valid %b data %h want 1/%h",
                         i, bus.rd_valid, bus.rd_data, 8'(i)); end
            drive(0, 8'h00, 1, 0, 0);
        end
        n_cmp++; if (bus.rd_valid !== 1'b0 || bus.count !== '0 || bus.overflow !== 1'b1)
        begin n_err++;
            $display("FAIL drained: valid %b count %0d ovf %b want 0/0/1",
                     bus.rd_valid, bus.count, bus.overflow); end
    endtask

    task automatic test_simul_full();
        logic [WIDTH-1:0] last;
        drive(0, 8'h00, 0, 1, 0);
        n_cmp++; if (bus.overflow !== 1'b0 || bus.high_water !== '0) begin n_err++;
            $display("FAIL clr_empty: ovf %b hw %0d want 0/0", bus.overflow, bus.high_water); end
        for (int i = 0; i < DEPTH; i++) drive(1, 8'($urandom), 0, 0, 0);
        drive(1, 8'h55, 1, 0, 0);
        n_cmp++; if (bus.count !== 16 || bus.overflow !== 1'b0 || bus.rd_data !== mq[0])
        begin n_err++;
            $display("FAIL simul_full: count %0d ovf %b head %h want 16/0/%h",
                     bus.count, bus.overflow, bus.rd_data, mq[0]); end
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++; if (bus.rd_data !== mq[0]) begin n_err++;
                $display("FAIL simul_drain_%0d: got %h want %h", i, bus.rd_data, mq[0]); end
            last = bus.rd_data;
            drive(0, 8'h00, 1, 0, 0);
        end
        n_cmp++; if (last !== 8'h55) begin n_err++;
            $display("FAIL simul_last: got %h want 55", last); end
    endtask

    task automatic test_wrap();
        int op;
        drive(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 3; i++) drive(1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);          // 0 write, 1 take, 2 both
            if (mq.size() == 1 && op == 1) op = 0;
            if (mq.size() == 3 && op == 0) op = 1;
            drive(op != 1, 8'($urandom), op != 0, 0, 0);
            n_cmp++; if (bus.count !== 5'(mq.size()) || bus.rd_data !== mq[0]) begin n_err++;
                $display("FAIL wrap_%0d: count %0d data %h want %0d/%h",
                         i, bus.count, bus.rd_data, mq.size(), mq[0]); end
        end
        n_cmp++; if (bus.high_water !== 3) begin n_err++;
            $display("FAIL wrap_hw: got %0d want 3", bus.high_water); end
        while (mq.size() > 1) drive(0, 8'h00, 1, 0, 0);
        drive(0, 8'h00, 0, 1, 0);
        n_cmp++; if (bus.high_water !== 1 || bus.overflow !== 1'b0) begin n_err++;
            $display("FAIL wrap_clr: hw %0d ovf %b want 1/0", bus.high_water, bus.overflow); end
    endtask

    task automatic test_reset_mid();
        while (mq.size() < DEPTH) drive(1, 8'($urandom), 0, 0, 0);
        drive(1, 8'hEE, 0, 0, 0);
        while (mq.size() > 5) drive(0, 8'h00, 1, 0, 0);
        n_cmp++; if (bus.count !== 5 || bus.overflow !== 1'b1) begin n_err++;
            $display("FAIL mid_setup: count %0d ovf %b want 5/1", bus.count, bus.overflow); end
        drive(1, 8'h77, 0, 0, 1);
        n_cmp++; if (bus.count !== '0 || bus.rd_valid !== 1'b0 || bus.full !== 1'b0 ||
                     bus.overflow !== 1'b0 || bus.high_water !== '0) begin n_err++;
            $display("FAIL mid_reset: count %0d valid %b full %b ovf %b hw %0d want all 0",
                     bus.count, bus.rd_valid, bus.full, bus.overflow, bus.high_water); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) < 4, $urandom_range(0, 199) == 0);
            n_cmp++;
            if (bus.count !== 5'(mq.size()) || bus.full !== (mq.size() == DEPTH) ||
                bus.rd_valid !== (mq.size() != 0) || bus.overflow !== movf ||
                bus.high_water !== 5'(mhw) || (mq.size() != 0 && bus.rd_data !== mq[0]))
            begin
                n_err++;
                $display("FAIL rand_%0d: count %0d full %b valid %b ovf %b hw %0d data %h want %0d/%b/%b/%b/%0d/%h",
                         i, bus.count, bus.full, bus.rd_valid, bus.overflow, bus.high_water,
                         bus.rd_data, mq.size(), mq.size() == DEPTH, mq.size() != 0, movf, mhw,
                         (mq.size() != 0) ? mq[0] : 8'h00);
            end
        end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_take = 1'b0;
        bus.ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fill_overflow();
        test_simul_full();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
